// File: rtl/bcd_stopwatch_up_pkg.sv
// Shared types and helpers for the up-counting mm:ss stopwatch.
// Holds the control states, the digit moduli and the limit validity check.
package bcd_stopwatch_up_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int BCD_MAX      = 9;
  localparam int SEC_TENS_MOD = 6;

  // A limit is usable only if every nibble is a digit its counter can actually reach.
  function automatic logic bcd_valid(input logic [15:0] value, input int min_tens_mod);
    bcd_valid = (int'(value[3:0])   <= BCD_MAX)
             && (int'(value[7:4])   <  SEC_TENS_MOD)
             && (int'(value[11:8])  <= BCD_MAX)
             && (int'(value[15:12]) <  min_tens_mod);
  endfunction

endpackage

// File: rtl/bcd_stopwatch_up_digit.sv
// One BCD up-counting digit with a ripple carry for the next digit.
// The carry is combinational so a whole chain advances on a single edge.
module bcd_digit_up
  import bcd_stopwatch_up_pkg::*;
#(
  parameter int MOD = BCD_MAX + 1
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       clear_sync,
  input  logic       enable,
  output logic [3:0] digit,
  output logic       carry
);

  logic at_max;

  assign at_max = (digit == 4'(MOD - 1));
  assign carry  = enable && at_max;

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      digit <= 4'd0;
    end else if (clear_sync) begin
      digit <= 4'd0;
    end else if (enable) begin
      digit <= at_max ? 4'd0 : digit + 4'd1;
    end else begin
      digit <= digit;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_up.sv
// Up-counting mm:ss stopwatch: four cascaded BCD digits under a run/pause/done
// controller, with an optional BCD limit that freezes the count when reached.
module bcd_stopwatch_up
  import bcd_stopwatch_up_pkg::*;
#(
  parameter int MIN_TENS_MOD = 6
) (
  input  logic        clock,
  input  logic        clr,
  input  logic        start,
  input  logic        stop,
  input  logic        tick,
  input  logic        loadn,
  input  logic [15:0] limit_data,
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic        running,
  output logic        done,
  output logic        tc
);

  state_t      state;
  logic [15:0] limit;
  logic        inc;
  logic        clear_sync;
  logic        c_so, c_st, c_mo, c_mt;
  logic [15:0] next_count;
  logic        hit_limit;
  logic        wrap;

  assign inc        = tick && (state == RUNNING) && !stop;
  assign clear_sync = stop && ((state == PAUSED) || (state == DONE));

  bcd_digit_up #(.MOD(BCD_MAX + 1)) u_sec_ones (
    .clock(clock), .clr(clr), .clear_sync(clear_sync), .enable(inc),
    .digit(sec_ones), .carry(c_so));
  bcd_digit_up #(.MOD(SEC_TENS_MOD)) u_sec_tens (
    .clock(clock), .clr(clr), .clear_sync(clear_sync), .enable(c_so),
    .digit(sec_tens), .carry(c_st));
  bcd_digit_up #(.MOD(BCD_MAX + 1)) u_min_ones (
    .clock(clock), .clr(clr), .clear_sync(clear_sync), .enable(c_st),
    .digit(min_ones), .carry(c_mo));
  bcd_digit_up #(.MOD(MIN_TENS_MOD)) u_min_tens (
    .clock(clock), .clr(clr), .clear_sync(clear_sync), .enable(c_mo),
    .digit(min_tens), .carry(c_mt));

  // Value each digit takes on this edge, so the limit compare lands on the same edge.
  function automatic logic [3:0] next_digit(input logic [3:0] d, input logic en, input logic cy);
    if (cy) begin
      next_digit = 4'd0;
    end else if (en) begin
      next_digit = d + 4'd1;
    end else begin
      next_digit = d;
    end
  endfunction

  assign next_count = {next_digit(min_tens, c_mo, c_mt), next_digit(min_ones, c_st, c_mo),
                       next_digit(sec_tens, c_so, c_st), next_digit(sec_ones, inc, c_so)};
  assign hit_limit  = inc && (limit != 16'h0000) && (next_count == limit);
  assign wrap       = inc && (limit == 16'h0000) && c_mt;

  assign running = (state == RUNNING);
  assign done    = (state == DONE);

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      limit <= 16'h0000;
      tc    <= 1'b0;
    end else begin
      tc <= wrap;
      case (state)
        IDLE: begin
          if (!loadn && bcd_valid(limit_data, MIN_TENS_MOD)) begin
            limit <= limit_data;
          end
          if (start && !stop) begin
            state <= RUNNING;
          end
        end
        RUNNING: begin
          if (stop) begin
            state <= PAUSED;
          end else if (hit_limit) begin
            state <= DONE;
          end
        end
        PAUSED: begin
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            state <= RUNNING;
          end
        end
        DONE: begin
          if (stop) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_up.sv
// Scoreboard bench: a seconds-based reference model queues the expected
// outputs per stimulus cycle, and a monitor pops and compares each cycle.
module tb_bcd_stopwatch_up;

  localparam int MOD  = 6;
  localparam int FULL = MOD * 10 * 60 - 1;

  logic        clock = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tick = 1'b0;
  logic        loadn = 1'b1;
  logic [15:0] limit_data = 16'h0000;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
  logic        running, done, tc;

  bcd_stopwatch_up #(.MIN_TENS_MOD(MOD)) dut (
    .clock(clock), .clr(clr), .start(start), .stop(stop), .tick(tick),
    .loadn(loadn), .limit_data(limit_data),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .done(done), .tc(tc));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        tc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference model: mode 0 idle, 1 running, 2 paused, 3 done; count and limit in seconds.
  int m_mode = 0;
  int m_cnt  = 0;
  int m_lim  = 0;

  function automatic logic [15:0] to_bcd(input int s);
    int mins, secs;
    mins = s / 60;
    secs = s % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
  endfunction

  function automatic int lim_secs(input logic [15:0] d);
    return (int'(d[15:12]) * 10 + int'(d[11:8])) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  function automatic bit valid(input logic [15:0] d);
    return (int'(d[3:0]) <= 9) && (int'(d[7:4]) <= 5) && (int'(d[11:8]) <= 9)
        && (int'(d[15:12]) < MOD);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic t, input logic ld,
                      input logic [15:0] data);
    bit w;
    start = s; stop = p; tick = t; loadn = ld; limit_data = data;
    @(posedge clock);
    w = 1'b0;
    case (m_mode)
      0: begin
        if (!ld && valid(data)) m_lim = lim_secs(data);
        if (s && !p) m_mode = 1;
      end
      1: begin
        if (p) m_mode = 2;
        else if (t) begin
          if (m_lim == 0) begin
            if (m_cnt == FULL) begin m_cnt = 0; w = 1'b1; end
            else m_cnt++;
          end else begin
            m_cnt++;
            if (m_cnt == m_lim) m_mode = 3;
          end
        end
      end
      2: begin
        if (p) begin m_mode = 0; m_cnt = 0; end
        else if (s) m_mode = 1;
      end
      default: begin
        if (p) begin m_mode = 0; m_cnt = 0; end
      end
    endcase
    sb.push_back('{to_bcd(m_cnt), m_mode == 1, m_mode == 3, w});
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_digits"}, {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check({tag, "_running"}, 16'(running), 16'h0000);
    check({tag, "_done"}, 16'(done), 16'h0000);
    check({tag, "_tc"}, 16'(tc), 16'h0000);
  endtask

  // Monitor: every cycle is an output; compare whatever the driver queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("digits", {min_tens, min_ones, sec_tens, sec_ones}, e.digits);
        check("running", 16'(running), 16'(e.running));
        check("done", 16'(done), 16'(e.done));
        check("tc", 16'(tc), 16'(e.tc));
      end
    end
  end

  initial begin
    logic s, p, t, ld;
    logic [15:0] d;
    clr = 1'b1;
    #2 check_reset_state("power_on");
    #1 clr = 1'b0;
    @(negedge clock);

    // Invalid load in IDLE, then a late load while running must both be ignored.
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0070);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0030);
    ticks(40);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);

    // start and stop together: stays IDLE; in PAUSED it clears.
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    ticks(3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);

    // Free-run through every carry up to 59:59, wrap, then tc must drop.
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    ticks(FULL + 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    ticks(2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);

    // Pause with a coincident tick, ticks while paused, resume.
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    ticks(5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    ticks(3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    ticks(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);

    // Limit 00:12: done on the 12th tick, holds, clears, and the limit survives.
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0012);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    ticks(15);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    ticks(13);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);

    // Asynchronous reset between edges while running at 00:07.
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    ticks(7);
    start = 1'b0; stop = 1'b0; tick = 1'b0; loadn = 1'b1;
    #2 clr = 1'b1;
    #1 check_reset_state("async_clr");
    m_mode = 0; m_cnt = 0; m_lim = 0;
    #1 clr = 1'b0;
    @(negedge clock);

    // Randomized traffic, with loads biased toward reachable valid limits.
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 7) == 0);
      t  = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        d = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      else
        d = 16'($urandom);
      step(s, p, t, ld, d);
    end

    #1 check("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_up.md
Name: bcd_stopwatch_up

Overview:
- Up-counting mm:ss stopwatch. It is the count-up counterpart of the team's down-counting mm:ss timer chain.
- It has four cascaded BCD digits advanced by a one-cycle tick strobe.
- A run/pause/done control FSM sits on top of the digits.
- An optional programmable limit stops counting when reached. Without a limit it free-runs and wraps.
- It feeds the display decoders and the alarm/buzzer logic in the same top level as the timer.

Parameters:
- MIN_TENS_MOD, 6: modulus of the minutes-tens digit. 6 gives 00:00–59:59; 10 gives 00:00–99:59.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  level sampled each clock; requests run.
- stop  input  1  level sampled each clock; requests pause, or clear when paused/done.
- tick  input  1  one-cycle count strobe (1 Hz enable); never used as a clock.
- loadn  input  1  active-low limit load; honoured only in IDLE.
- limit_data  input  16  BCD limit {min_tens, min_ones, sec_tens, sec_ones}.
- sec_ones  output  4  BCD seconds units.
- sec_tens  output  4  BCD seconds tens, 0–5.
- min_ones  output  4  BCD minutes units.
- min_tens  output  4  BCD minutes tens, 0 to MIN_TENS_MOD-1.
- running  output  1  high while in RUNNING.
- done  output  1  high while in DONE.
- tc  output  1  one-cycle pulse on full-scale wrap.

Behaviour:
- **Reset** (clr=1, asynchronous, takes effect immediately, mid-operation included):
  - all digits 0, limit register 0000.
  - state IDLE, running=0, done=0, tc=0.
- **Outputs**: all registered; running/done decode the state register.
- **Digit cascade**:
  - sec_ones counts 0–9. sec_tens counts 0–5. min_ones counts 0–9. min_tens counts 0 to MIN_TENS_MOD-1.
  - Each digit increments when its enable is high. At max it rolls to 0 and asserts carry = enable && at_max.
  - Enable chain: sec_ones enable = inc. Each higher digit is enabled by the lower digit's carry.
  - inc = tick && (state==RUNNING) && !stop.
  - Count updates on the same clock edge that samples tick=1: latency 1 edge, no pipeline.
- **States**: IDLE, RUNNING, PAUSED, DONE.
- **IDLE**:
  - Count is 0.
  - loadn=0 loads limit_data into the limit register on that edge, if it is valid BCD: each digit ≤ its max, sec_tens ≤5, min_tens < MIN_TENS_MOD. Invalid load is ignored (limit unchanged).
  - start=1 && stop=0 → RUNNING.
  - tick is ignored.
- **RUNNING**:
  - stop=1 → PAUSED; a tick in the same cycle is discarded.
  - Otherwise, if tick=1, increment.
  - If limit≠0000 and the next count equals limit → DONE on the same edge; done=1 from that edge.
  - If limit=0000 (free-run) and count is at full scale (59:59, or 99:59 for MOD 10) and tick=1 → count 00:00, tc=1 for exactly one cycle; stay RUNNING.
  - start is ignored.
- **PAUSED**:
  - Count is held; tick is ignored.
  - stop=1 → IDLE with all digits cleared; stop has priority over start.
  - Otherwise start=1 → RUNNING.
- **DONE**:
  - Count is held at the limit; tick and start are ignored.
  - stop=1 → IDLE with all digits cleared. The limit is kept.
- **Limit register**: changes only on reset or a valid IDLE load.
- **loadn** in any state other than IDLE is ignored.
- **tc** is 0 in every cycle except the one following a wrap edge. It is never asserted in limit mode, since a limit of 00:00 means free-run.
- **Illegal states**: the state encoding must recover to IDLE from any unused code on the next edge.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RUNNING, PAUSED, DONE)
  - constants BCD_MAX=9 and SEC_TENS_MOD=6
  - a BCD-valid check function for limit_data.
- Sub-module bcd_digit_up:
  - parameter MOD; ports clock, clr, clear_sync, enable, digit[3:0], carry.
  - Instantiated four times. The FSM drives clear_sync for the stop-clear transitions.

Test Plan:
1. Reset mid-run:
   - Stimulus: run to 00:07, then pulse clr asynchronously between clock edges.
   - Response: digits 0000, running=0, done=0, tc=0 immediately, before the next edge.
2. Free-run wrap (MIN_TENS_MOD=6, limit 0000):
   - Stimulus: start, then apply ticks until 59:59, then one more tick.
   - Response: count 00:00, tc=1 for exactly one cycle, running stays 1. Also check 00:59 → 01:00 and 09:59 → 10:00 carries.
3. Limit stop:
   - Stimulus: in IDLE, loadn=0 with limit_data=16'h0012; start; 12 ticks.
   - Response: done=1 on the 12th tick edge, count 00:12, running=0. Further ticks leave the count at 00:12.
   - Then stop → IDLE, count 00:00, limit still 0012.
4. Pause/resume:
   - Stimulus: run to 00:05; stop and tick in the same cycle.
   - Response: count stays 00:05, state PAUSED.
   - Then 3 ticks → still 00:05. Then start, 1 tick → 00:06.
   - Then stop twice → IDLE, 00:00.
5. Invalid/late load:
   - Stimulus: loadn=0 with 16'h0070 (sec_tens=7) in IDLE.
   - Response: limit unchanged (0000).
   - Stimulus: loadn=0 with 16'h0030 while RUNNING.
   - Response: ignored; the counter free-runs past 00:30.
6. start+stop together:
   - Stimulus: start=stop=1 in IDLE.
   - Response: stays IDLE.
   - Stimulus: start=stop=1 in PAUSED.
   - Response: → IDLE, cleared.
